// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Serial pattern (sync-word) detector with a run-time loadable N-bit pattern,
// run-time selectable overlapping / non-overlapping detection and a saturating
// match counter.
//
// Optional build macro:
//   SEQDET_REG_OUT_EN - when defined, y comes from a flop and asserts one cycle
//                       after the final pattern bit. When undefined, y is the
//                       combinational Mealy match term.
//
// Parameters:
//   N        pattern length in bits (2..16)
//   PATTERN  reset value of the pattern register; PATTERN[N-1] arrives first
//   CW       match counter width (1..16)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         x valid strobe
//   x          serial data bit
//   ovl        1 = overlapping detection, 0 = non-overlapping
//   pat_ld     load pat_in into the pattern register (wins over en)
//   pat_in     new pattern value
//   cnt_clr    synchronous clear of the match counter (wins over a match)
//   y          match indication
//   match_cnt  saturating count of matches
//   cnt_sat    high while match_cnt is at its maximum
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          x,
    input  logic          ovl,
    input  logic          pat_ld,
    input  logic [N-1:0]  pat_in,
    input  logic          cnt_clr,
    output logic          y,
    output logic [CW-1:0] match_cnt,
    output logic          cnt_sat
);

    // Elaboration-time range checks.
    generate
        if ((N < 2) || (N > 16)) begin : g_bad_n
            $error("seq_detector_param: N must be in 2..16");
        end
        if ((CW < 1) || (CW > 16)) begin : g_bad_cw
            $error("seq_detector_param: CW must be in 1..16");
        end
    endgenerate

    // fill only has to reach N-1, so $clog2(N) bits suffice (at least 1).
    localparam int             FW       = (N > 2) ? $clog2(N) : 1;
    localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    logic [N-1:0]  pat_q,  pat_d;
    logic [N-2:0]  hist_q, hist_d;
    logic [N-2:0]  hist_shift;
    logic [FW-1:0] fill_q, fill_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          accept;
    logic          match;

    // History shifted by one accepted bit: newest bit enters at hist[0].
    assign hist_shift[0] = x;
    generate
        for (genvar gi = 1; gi < N - 1; gi++) begin : g_hist_shift
            assign hist_shift[gi] = hist_q[gi-1];
        end
    endgenerate

    assign accept = en & ~pat_ld;
    // A match needs N-1 valid history bits plus the bit presented now.
    assign match  = accept & (fill_q == FILL_MAX) & ({hist_q, x} == pat_q);

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;

        if (pat_ld) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = hist_shift;
            if (match && !ovl) begin
                // Non-overlapping: the next match must be built from N fresh bits.
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef SEQDET_REG_OUT_EN
    // Registered output: match is already forced low by pat_ld, so loading a
    // pattern clears the flop on the same edge.
    logic y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= 1'b0;
        end else begin
            y_q <= match;
        end
    end

    assign y = y_q;
`else
    // Mealy output; rst gates it so y is low for the whole reset pulse.
    assign y = match & ~rst;
`endif

    assign match_cnt = cnt_q;
    assign cnt_sat   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         x = 1'b0;
    logic         ovl = 1'b0;
    logic         pat_ld = 1'b0;
    logic [N-1:0] pat_in = '0;
    logic         cnt_clr = 1'b0;

    logic         y8, y2;
    logic [7:0]   cnt8;
    logic [1:0]   cnt2;
    logic         sat8, sat2;

    always #5 clk = ~clk;

    seq_detector_param #(.N(N), .PATTERN(4'b1011), .CW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .ovl(ovl), .pat_ld(pat_ld),
        .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y8), .match_cnt(cnt8), .cnt_sat(sat8)
    );

    seq_detector_param #(.N(N), .PATTERN(4'b1011), .CW(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .x(x), .ovl(ovl), .pat_ld(pat_ld),
        .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    // ---------------- reference model ----------------
    // acc holds the bits accepted since the last restart (reset, load or
    // non-overlap match), keeping only the newest N-1 of them.
    bit           acc[$];
    logic [N-1:0] pat_m;
    int           cnt8_m, cnt2_m;
    bit           yreg_m;

    int n_pass  = 0;
    int n_total = 0;
    int step_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (step %0d)", tag, obs, exp, step_no);
    endtask

    task automatic model_reset();
        acc.delete();
        pat_m  = 4'b1011;
        cnt8_m = 0;
        cnt2_m = 0;
        yreg_m = 0;
    endtask

    function automatic bit model_match(input bit e, input bit l, input bit xi);
        logic [N-1:0] w;
        if (!e || l || acc.size() != N - 1) return 0;
        w = '0;
        foreach (acc[i]) w = {w[N-2:0], acc[i]};
        w = {w[N-2:0], xi};
        return (w == pat_m);
    endfunction

    // One clock cycle of stimulus: drive at negedge, check before the rising
    // edge, then advance the model across that edge.
    task automatic step(input bit r, input bit e, input bit xi, input bit o,
                        input bit l, input logic [N-1:0] p, input bit c);
        bit m, yexp;
        step_no++;
        @(negedge clk);
        rst = r; en = e; x = xi; ovl = o; pat_ld = l; pat_in = p; cnt_clr = c;
        if (r) model_reset();
        #1;
        m = !r && model_match(e, l, xi);
`ifdef SEQDET_REG_OUT_EN
        yexp = yreg_m;
`else
        yexp = m;
`endif
        chk("y", 32'(y8), 32'(yexp));
        chk("y_cw2", 32'(y2), 32'(yexp));
        chk("match_cnt", 32'(cnt8), 32'(cnt8_m));
        chk("match_cnt_cw2", 32'(cnt2), 32'(cnt2_m));
        chk("cnt_sat", 32'(sat8), 32'(cnt8_m == 255));
        chk("cnt_sat_cw2", 32'(sat2), 32'(cnt2_m == 3));
        $display("step %0d rst=%0b en=%0b x=%0b ovl=%0b ld=%0b pat_in=%b clr=%0b y=%0b cnt=%0d cnt_cw2=%0d",
                 step_no, r, e, xi, o, l, p, c, y8, cnt8, cnt2);
        @(posedge clk);
        if (!r) begin
            if (l) begin
                pat_m = p;
                acc.delete();
            end else if (e) begin
                if (m && !o) acc.delete();
                else begin
                    acc.push_back(xi);
                    if (acc.size() > N - 1) void'(acc.pop_front());
                end
            end
            if (c) begin
                cnt8_m = 0;
                cnt2_m = 0;
            end else if (m) begin
                if (cnt8_m < 255) cnt8_m++;
                if (cnt2_m < 3) cnt2_m++;
            end
            yreg_m = m;
        end
    endtask

    task automatic feed(input logic [31:0] bits, input int len, input bit o);
        for (int i = len - 1; i >= 0; i--) step(0, 1, bits[i], o, 0, 4'b0000, 0);
    endtask

    // Clean slate: reload the default pattern and clear the counter.
    task automatic restart();
        step(0, 0, 0, 0, 1, 4'b1011, 1);
    endtask

    initial begin
        model_reset();
        // Reset state
        step(1, 1, 1, 1, 0, 4'b0000, 0);
        step(1, 0, 0, 0, 0, 4'b0000, 0);

        // Overlapping: 1011011 -> matches on bits 4 and 7
        restart();
        feed(32'b1011011, 7, 1);
        #1 chk("ovl_total", 32'(cnt8), 32'd2);

        // Non-overlapping: 1011011 then 1 -> one match only
        restart();
        feed(32'b10110111, 8, 0);
        #1 chk("novl_total", 32'(cnt8), 32'd1);

        // Gaps with x toggling while en=0
        restart();
        feed(32'b10, 2, 1);
        step(0, 0, 1, 1, 0, 4'b0000, 0);
        step(0, 0, 0, 1, 0, 4'b0000, 0);
        feed(32'b11011, 5, 1);
        #1 chk("gap_total", 32'(cnt8), 32'd2);
        // Reload pattern to 0110
        step(0, 1, 1, 1, 1, 4'b0110, 0);
        feed(32'b0110, 4, 1);
        #1 chk("reload_total", 32'(cnt8), 32'd3);

        // Reset mid-stream
        restart();
        feed(32'b101, 3, 1);
        step(1, 1, 1, 1, 0, 4'b0000, 0);
        feed(32'b1011, 4, 1);
        #1 chk("rst_total", 32'(cnt8), 32'd1);

        // Saturation of the 2-bit counter: five overlapping matches
        restart();
        feed(32'b1011011011011011, 16, 1);
        #1 chk("sat_cw2", 32'(cnt2), 32'd3);
        chk("sat_flag_cw2", 32'(sat2), 32'd1);
        chk("sat_total", 32'(cnt8), 32'd5);

        // Clear coincident with a match
        restart();
        feed(32'b101, 3, 1);
        step(0, 1, 1, 1, 0, 4'b0000, 1);
        #1 chk("clr_wins", 32'(cnt8), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 80,
                 1'($urandom),
                 1'($urandom),
                 $urandom_range(0, 99) < 3,
                 4'($urandom),
                 $urandom_range(0, 99) < 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
